// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer and its return-address stack.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_pkg;

  localparam int PC_WIDTH_DEF  = 32;
  localparam int RAS_DEPTH_DEF = 8;

  // Source of the next PC value, resolved by the priority select in the top level.
  typedef enum logic [2:0] {
    PCSEL_INC  = 3'd0,
    PCSEL_BR   = 3'd1,
    PCSEL_JMP  = 3'd2,
    PCSEL_CALL = 3'd3,
    PCSEL_RET  = 3'd4,
    PCSEL_HOLD = 3'd5
  } pcsel_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop one entry per edge, oldest entry overwritten when full.
// Latency: push/pop take effect at the next negedge clk; top_data/empty/full are registered-state derived.
// Backpressure: none; push when full or pop when empty raise err_evt for one cycle instead of stalling.
// Ports: clk, rst (sync, active-high), push, pop, push_data -> top_data, empty, full, err_evt.
module pc_ras #(
  parameter int WIDTH = pc_pkg::PC_WIDTH_DEF,
  parameter int DEPTH = pc_pkg::RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             err_evt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top;
  logic [CW-1:0]    count;
  logic [PW-1:0]    top_inc;
  logic [PW-1:0]    top_dec;

  // Explicit wrap so non-power-of-two depths stay inside the array.
  always_comb begin
    top_inc = (top == PW'(DEPTH - 1)) ? '0 : top + PW'(1);
    top_dec = (top == '0) ? PW'(DEPTH - 1) : top - PW'(1);
  end

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign top_data = mem[top];
  assign err_evt  = (push && full) || (pop && empty);

  // top points at the newest entry; when full, top_inc is the oldest slot,
  // so a push there drops the oldest address and the count saturates.
  always_ff @(negedge clk) begin
    if (rst) begin
      top   <= PW'(DEPTH - 1);
      count <= '0;
    end else if (push) begin
      top <= top_inc;
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      top   <= top_dec;
      count <= count - CW'(1);
    end
  end

  // Contents need no reset; validity is tracked by count.
  always_ff @(negedge clk) begin
    if (push && !rst) mem[top_inc] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, relative branch, jump, call/return with hardware RAS.
// Latency: one edge; next_pc is combinational and loaded into pc at the next negedge clk.
// Backpressure: stall holds pc, stack and flags; all other requests that cycle are dropped.
// Ports: clk, rst, stall, branch_en/branch_offset, jump_en, call_en, ret_en, jump_target
//        -> pc, next_pc, ras_empty, ras_full, ras_err (sticky until rst).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH_DEF,
  parameter int               RAS_DEPTH    = RAS_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  pcsel_t           sel;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_br;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_err_evt;

  assign pc_inc = pc + WIDTH'(1);
  assign pc_br  = pc + branch_offset;

  always_comb begin
    sel = PCSEL_INC;
    if (stall)          sel = PCSEL_HOLD;
    else if (ret_en)    sel = PCSEL_RET;
    else if (call_en)   sel = PCSEL_CALL;
    else if (jump_en)   sel = PCSEL_JMP;
    else if (branch_en) sel = PCSEL_BR;
  end

  always_comb begin
    next_pc = pc_inc;
    if (rst) begin
      next_pc = RESET_VECTOR;
    end else begin
      case (sel)
        PCSEL_HOLD: next_pc = pc;
        // Underflowing return falls through to sequential execution.
        PCSEL_RET:  next_pc = ras_empty ? pc_inc : ras_top;
        PCSEL_CALL: next_pc = jump_target;
        PCSEL_JMP:  next_pc = jump_target;
        PCSEL_BR:   next_pc = pc_br;
        default:    next_pc = pc_inc;
      endcase
    end
  end

  // Reset discards any same-cycle request, so the stack never moves during rst.
  assign ras_push = !rst && (sel == PCSEL_CALL);
  assign ras_pop  = !rst && (sel == PCSEL_RET);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .err_evt   (ras_err_evt)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      pc      <= RESET_VECTOR;
      ras_err <= 1'b0;
    end else begin
      pc <= next_pc;
      if (ras_err_evt) ras_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int W = 32;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst, stall, branch_en, jump_en, call_en, ret_en;
  logic [W-1:0] branch_offset, jump_target;
  logic [W-1:0] pc, next_pc;
  logic         ras_empty, ras_full, ras_err;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH        (W),
    .RAS_DEPTH    (D),
    .RESET_VECTOR ('0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .jump_target   (jump_target),
    .pc            (pc),
    .next_pc       (next_pc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_err       (ras_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] pc;
    logic         e;
    logic         f;
    logic         err;
  } exp_t;

  exp_t         sbq[$];
  // Reference model: unbounded queue trimmed from the front to D entries.
  logic [W-1:0] mpc;
  logic [W-1:0] mstk[$];
  logic         merr;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string name, input logic r, input logic s, input logic re,
                      input logic ce, input logic je, input logic be,
                      input logic [W-1:0] off, input logic [W-1:0] tgt);
    exp_t e;
    exp_t got;
    rst = r; stall = s; ret_en = re; call_en = ce; jump_en = je; branch_en = be;
    branch_offset = off; jump_target = tgt;
    #1;
    if (r) begin
      mpc = '0; mstk.delete(); merr = 1'b0;
    end else if (s) begin
      mpc = mpc;
    end else if (re) begin
      if (mstk.size() > 0) mpc = mstk.pop_back();
      else begin mpc = mpc + 32'd1; merr = 1'b1; end
    end else if (ce) begin
      mstk.push_back(mpc + 32'd1);
      if (mstk.size() > D) begin
        void'(mstk.pop_front());
        merr = 1'b1;
      end
      mpc = tgt;
    end else if (je) begin
      mpc = tgt;
    end else if (be) begin
      mpc = mpc + off;
    end else begin
      mpc = mpc + 32'd1;
    end
    e.pc = mpc; e.e = (mstk.size() == 0); e.f = (mstk.size() == D); e.err = merr;
    sbq.push_back(e);
    check({name, ".next_pc"}, next_pc, e.pc);
    @(negedge clk);
    #1;
    got = sbq.pop_front();
    check({name, ".pc"},        pc,                got.pc);
    check({name, ".ras_empty"}, W'(ras_empty),     W'(got.e));
    check({name, ".ras_full"},  W'(ras_full),      W'(got.f));
    check({name, ".ras_err"},   W'(ras_err),       W'(got.err));
  endtask

  task automatic inc(input string n);                   step(n, 0, 0, 0, 0, 0, 0, '0, '0);  endtask
  task automatic jmp(input string n, input logic [W-1:0] t); step(n, 0, 0, 0, 0, 1, 0, '0, t); endtask
  task automatic br(input string n, input logic [W-1:0] o);  step(n, 0, 0, 0, 0, 0, 1, o, '0); endtask
  task automatic call(input string n, input logic [W-1:0] t); step(n, 0, 0, 0, 1, 0, 0, '0, t); endtask
  task automatic ret(input string n);                   step(n, 0, 0, 1, 0, 0, 0, '0, '0);  endtask
  task automatic reset(input string n);                 step(n, 1, 0, 0, 0, 0, 0, '0, '0);  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
    branch_offset = '0; jump_target = '0;
    mpc = '0; merr = 1'b0;

    // Reset then sequential increment 1..4
    reset("reset");
    for (int i = 0; i < 4; i++) inc("inc");

    // Branch backwards and PC wrap-around
    jmp("jmp10", 32'd10);
    br("br_neg3", 32'hFFFF_FFFD);
    jmp("jmp_max", 32'hFFFF_FFFF);
    inc("wrap");

    // Nested call/return
    jmp("jmp5", 32'd5);
    call("call100", 32'h100);
    inc("inc101");
    call("call200", 32'h200);
    ret("ret_inner");
    ret("ret_outer");

    // Overflow: nine calls into an eight-entry stack, then drain plus one underflow
    for (int i = 0; i < 9; i++) call("ovf_call", W'(32'h1000 + i * 16));
    for (int i = 0; i < 9; i++) ret("ovf_ret");

    // Priority: return beats call/jump/branch
    reset("reset2");
    call("pri_call40", 32'h40);
    call("pri_call80", 32'h80);
    step("prio_all", 0, 0, 1, 1, 1, 1, 32'd4, 32'h999);

    // Stall with call pending: nothing moves
    step("stall_call", 0, 1, 0, 1, 0, 0, '0, 32'h777);
    ret("after_stall_ret");

    // Return directly after a call returns that call's address
    call("bb_call", 32'h500);
    ret("bb_ret");

    // Reset during a call with three entries on the stack
    call("mr_call1", 32'h300);
    call("mr_call2", 32'h310);
    call("mr_call3", 32'h320);
    step("mid_reset", 1, 0, 0, 1, 0, 0, '0, 32'h330);
    ret("post_reset_underflow");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the soft processor; successor to the fixed 32-bit counter-plus-adder pair. Holds the PC register, selects the next PC from increment, PC-relative branch, absolute jump, call and return, and keeps a hardware return-address stack (RAS) for calls and returns. Sits between the control decoder and instruction-memory address port, and updates on the same falling clock edge the core already uses for PC updates.

## Interface
- WIDTH, 32: PC and address width in bits.
- RAS_DEPTH, 8: return-address stack entries, ≥2.
- RESET_VECTOR, 0: PC value after reset.

- clk  in  1: clock; all state updates on negedge clk.
- rst  in  1: synchronous active-high reset, sampled at negedge clk.
- stall  in  1: hold PC and RAS; all other requests ignored.
- branch_en  in  1: PC-relative branch.
- branch_offset  in  WIDTH: two's-complement offset added to the current PC.
- jump_en  in  1: absolute jump.
- call_en  in  1: push the return address, then go to jump_target.
- ret_en  in  1: pop the RAS into the PC.
- jump_target  in  WIDTH: absolute target for jump and call.
- pc  out  WIDTH: registered current PC.
- next_pc  out  WIDTH: combinational value the PC takes at the next edge.
- ras_empty  out  1: stack holds 0 entries.
- ras_full  out  1: stack holds RAS_DEPTH entries.
- ras_err  out  1: sticky error flag for overflow or underflow; cleared only by rst.

## Operation
- Requests are evaluated in this priority order: rst > stall > ret_en > call_en > jump_en > branch_en > increment. Lower-priority requests asserted in the same cycle are ignored.
- **Increment:** next_pc = pc + 1.
- **Branch:** next_pc = pc + branch_offset.
- **Jump:** next_pc = jump_target.
- **Call:** push pc + 1, then next_pc = jump_target.
- **Return:** next_pc = top of stack, then pop.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH. Wrap-around is silent and sets no flag.
- **RAS:** circular buffer with a top pointer and an entry count. Count width is clog2(RAS_DEPTH+1).
- **Call when full:** the oldest entry is overwritten, the count stays at RAS_DEPTH, and ras_err is set. The call still redirects to jump_target.
- **Return when empty:** next_pc = pc + 1, the stack is unchanged, and ras_err is set.
- **Reset:**
  - pc = RESET_VECTOR, count = 0.
  - ras_empty = 1, ras_full = 0, ras_err = 0.
  - Stack contents are don't-care.
  - Reset asserted during any request discards that request.

## Timing
- pc changes only at negedge clk. next_pc is valid combinationally within the same cycle.
- Latency is one edge: a request presented during a cycle is reflected in pc after the next negedge.
- ras_empty and ras_full are derived from the registered count and change on the same edge as the push or pop.
- When ret_en and call_en are both asserted, only the return executes. No simultaneous push and pop occurs.
- While stall is asserted, next_pc = pc and the flags are frozen.
- Back-to-back calls or returns on consecutive cycles are supported, one per cycle.
- A return in the cycle immediately after a call returns the address that call pushed.

## Structure
- Shared package pc_pkg holds:
  - the next-PC select encoding (PCSEL_INC, PCSEL_BR, PCSEL_JMP, PCSEL_CALL, PCSEL_RET, PCSEL_HOLD);
  - the default WIDTH and RAS_DEPTH constants.
- Sub-module pc_ras contains the stack storage, top pointer, count, full/empty logic and the error-event output, with push, pop and push_data ports.
- The top level contains the priority select, the adders, the PC register and the sticky error register.

## Test plan
- **Reset and increment:** assert rst, release it, run 4 cycles → pc sequence 0, 1, 2, 3, 4; ras_empty = 1, ras_err = 0.
- **Branch and wrap-around:**
  - pc = 10, branch_offset = −3 (0xFFFFFFFD) → pc = 7.
  - pc = 0xFFFFFFFF, increment → pc = 0, ras_err still 0.
- **Nested call and return:**
  - pc = 5, call 0x100; then pc = 0x101, call 0x200.
  - Return twice → pc = 0x102, then pc = 6; ras_empty = 1.
- **Overflow and underflow** (RAS_DEPTH = 8):
  - 9 calls → ras_full = 1 and ras_err = 1; 8 returns yield the newest 8 return addresses.
  - A 9th return → pc increments and ras_empty stays 1.
- **Priority and stall:**
  - ret_en, call_en, jump_en and branch_en asserted together → only the return takes effect.
  - stall with call_en → pc and count unchanged.
- **Mid-operation reset:** rst asserted together with a call while count = 3 → pc = RESET_VECTOR, count = 0, ras_err = 0.
